// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage with a two-state FETCH/HOLD controller.
// In FETCH it requests the word at pc and waits for imemAck. In HOLD it
// presents the captured word to the decoder until it is consumed (stall=0).
// On consume it loads the next PC and increments the retired counter.
// At most one memory request is ever outstanding.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rstN        : synchronous active-low reset
//   imemReq     : fetch request (high in FETCH)
//   imemAddr    : fetch address (current pc)
//   imemAck     : memory returned imemRData this cycle
//   imemRData   : instruction word from memory
//   instr       : held instruction word
//   instrValid  : instr valid and awaiting consumption (high in HOLD)
//   pc          : address of the held instruction
//   pcPlus4     : pc + 4, the link value
//   stall       : downstream cannot consume instr this cycle
//   pcSrcCtrl   : next-PC select (0 INC4, 1 J, 2 JR, 3 BRANCH)
//   jAddr       : jump target field
//   jrTarget    : register target for JR
//   imm         : sign-extended branch offset in words
//   branchTaken : resolved branch condition
//   retired     : count of consumed instructions (wraps)

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ICNT_W   = 32
) (
   input  logic              clk,
   input  logic              rstN,
   output logic              imemReq,
   output logic [31:0]       imemAddr,
   input  logic              imemAck,
   input  logic [31:0]       imemRData,
   output logic [31:0]       instr,
   output logic              instrValid,
   output logic [31:0]       pc,
   output logic [31:0]       pcPlus4,
   input  logic              stall,
   input  logic [1:0]        pcSrcCtrl,
   input  logic [25:0]       jAddr,
   input  logic [31:0]       jrTarget,
   input  logic [31:0]       imm,
   input  logic              branchTaken,
   output logic [ICNT_W-1:0] retired
);

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [1:0] SEL_INC4   = 2'd0;
   localparam logic [1:0] SEL_J      = 2'd1;
   localparam logic [1:0] SEL_JR     = 2'd2;
   localparam logic [1:0] SEL_BRANCH = 2'd3;

   state_t            state_reg, state_next;
   logic [31:0]       pc_reg, pc_next;
   logic [31:0]       instr_reg, instr_next;
   logic [ICNT_W-1:0] retired_reg, retired_next;
   logic [31:0]       pc_plus4;
   logic [31:0]       target_pc;

   // Low bits of jrTarget are forced to word alignment and the top bits of
   // imm fall off the word-to-byte shift; they are intentionally unused.
   logic unused_bits;
   assign unused_bits = &{1'b0, jrTarget[1:0], imm[31:30]};

   assign pc_plus4 = pc_reg + 32'd4;

   // Next PC, computed from the control inputs of the current cycle; it is
   // only committed in the consume cycle.
   always_comb begin
      target_pc = pc_plus4;
      case (pcSrcCtrl)
         SEL_INC4:   target_pc = pc_plus4;
         SEL_J:      target_pc = {pc_plus4[31:28], jAddr, 2'b00};
         SEL_JR:     target_pc = {jrTarget[31:2], 2'b00};
         SEL_BRANCH: target_pc = branchTaken ? (pc_plus4 + {imm[29:0], 2'b00})
                                             : pc_plus4;
         default:    target_pc = pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_reg   <= FETCH;
         pc_reg      <= RESET_PC;
         instr_reg   <= 32'h0000_0000;
         retired_reg <= '0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         instr_reg   <= instr_next;
         retired_reg <= retired_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      instr_next   = instr_reg;
      retired_next = retired_reg;
      case (state_reg)
         FETCH: begin
            // stall has no effect here; only the ack moves us on
            if (imemAck) begin
               instr_next = imemRData;
               state_next = HOLD;
            end
         end
         HOLD: begin
            // imemAck is ignored: no request is outstanding in HOLD
            if (!stall) begin
               pc_next      = target_pc;
               retired_next = retired_reg + ICNT_W'(1);
               state_next   = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   assign imemReq    = (state_reg == FETCH);
   assign instrValid = (state_reg == HOLD);
   assign imemAddr   = pc_reg;
   assign pc         = pc_reg;
   assign pcPlus4    = pc_plus4;
   assign instr      = instr_reg;
   assign retired    = retired_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. A transaction-level model (holding an
// instruction or not, its pc/word, the retired count) is updated on every
// rising edge from the sampled inputs; a compare process checks the DUT
// against it on every falling edge. Directed literal checks pin the model.

module tb_fetch_unit;

   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rstN;
   logic          imemReq;
   logic [31:0]   imemAddr;
   logic          imemAck;
   logic [31:0]   imemRData;
   logic [31:0]   instr;
   logic          instrValid;
   logic [31:0]   pc;
   logic [31:0]   pcPlus4;
   logic          stall;
   logic [1:0]    pcSrcCtrl;
   logic [25:0]   jAddr;
   logic [31:0]   jrTarget;
   logic [31:0]   imm;
   logic          branchTaken;
   logic [IW-1:0] retired;

   int total  = 0;
   int passed = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .ICNT_W(IW)) dut (
      .clk(clk), .rstN(rstN), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemAck(imemAck), .imemRData(imemRData), .instr(instr),
      .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4), .stall(stall),
      .pcSrcCtrl(pcSrcCtrl), .jAddr(jAddr), .jrTarget(jrTarget), .imm(imm),
      .branchTaken(branchTaken), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] model_target(input logic [31:0] p, input logic [1:0] sel,
                                                input logic [25:0] j, input logic [31:0] jr,
                                                input logic [31:0] iv, input logic tk);
      logic [31:0] seq;
      seq = p + 32'd4;
      case (sel)
         2'd0:    return seq;
         2'd1:    return (seq & 32'hF000_0000) | ({6'b0, j} * 32'd4);
         2'd2:    return jr & 32'hFFFF_FFFC;
         default: return tk ? seq + iv * 32'd4 : seq;
      endcase
   endfunction

   logic          m_known = 1'b0;
   logic          m_have;
   logic [31:0]   m_pc;
   logic [31:0]   m_instr;
   logic [IW-1:0] m_ret;

   always @(posedge clk) begin
      if (!rstN) begin
         m_known <= 1'b1;
         m_have  <= 1'b0;
         m_pc    <= 32'h0;
         m_instr <= 32'h0;
         m_ret   <= '0;
      end else if (!m_have) begin
         if (imemAck) begin
            m_have  <= 1'b1;
            m_instr <= imemRData;
         end
      end else if (!stall) begin
         m_have <= 1'b0;
         m_pc   <= model_target(m_pc, pcSrcCtrl, jAddr, jrTarget, imm, branchTaken);
         m_ret  <= m_ret + 1'b1;
      end
   end

   always @(negedge clk) begin
      if (m_known) begin
         chk("m_req",     {31'b0, imemReq},    {31'b0, !m_have});
         chk("m_valid",   {31'b0, instrValid}, {31'b0, m_have});
         chk("m_addr",    imemAddr, m_pc);
         chk("m_pc",      pc, m_pc);
         chk("m_pcplus4", pcPlus4, m_pc + 32'd4);
         chk("m_retired", 32'(retired), 32'(m_ret));
         if (m_have) chk("m_instr", instr, m_instr);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_one(input logic [31:0] data);
      imemAck   = 1'b1;
      imemRData = data;
      $display("fetch  addr=%h data=%h", imemAddr, data);
      step();
      imemAck = 1'b0;
   endtask

   task automatic consume(input logic [1:0] sel, input logic [25:0] j, input logic [31:0] jr,
                          input logic [31:0] iv, input logic tk);
      pcSrcCtrl = sel; jAddr = j; jrTarget = jr; imm = iv; branchTaken = tk;
      stall = 1'b0;
      step();
      stall = 1'b1;
      pcSrcCtrl = 2'd0;
      $display("commit sel=%0d next_addr=%h retired=%0d", sel, imemAddr, retired);
   endtask

   logic [31:0]   seen [4];
   int            n_seen;
   logic [IW-1:0] r0;

   initial begin
      rstN = 1'b0; imemAck = 1'b0; imemRData = 32'h0; stall = 1'b0;
      pcSrcCtrl = 2'd0; jAddr = 26'h0; jrTarget = 32'h0; imm = 32'h0; branchTaken = 1'b0;
      step(); step();
      chk("rst_req",     {31'b0, imemReq}, 32'd1);
      chk("rst_addr",    imemAddr, 32'h0);
      chk("rst_valid",   {31'b0, instrValid}, 32'd0);
      chk("rst_instr",   instr, 32'h0);
      chk("rst_retired", 32'(retired), 32'd0);
      rstN = 1'b1;

      // zero-wait memory, INC4, no stall
      n_seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (imemReq) begin
            if (n_seen < 4) seen[n_seen] = imemAddr;
            n_seen++;
            imemAck = 1'b1;
            imemRData = imemAddr * 32'd3 + 32'h1000_0001;
         end else begin
            imemAck = 1'b0;
         end
         step();
      end
      imemAck = 1'b0;
      chk("seq_count", 32'(n_seen), 32'd4);
      chk("seq_a0", seen[0], 32'h0);
      chk("seq_a1", seen[1], 32'h4);
      chk("seq_a2", seen[2], 32'h8);
      chk("seq_a3", seen[3], 32'hC);
      chk("seq_retired", 32'(retired), 32'd4);
      stall = 1'b1;

      // J and JR targets
      fetch_one(32'hAAAA_0001);
      consume(2'd2, 26'h0, 32'h0040_0010, 32'h0, 1'b0);
      chk("jr_setup", imemAddr, 32'h0040_0010);
      fetch_one(32'hAAAA_0002);
      chk("held_pc", pc, 32'h0040_0010);
      consume(2'd1, 26'h0000100, 32'h0, 32'h0, 1'b0);
      chk("j_target", imemAddr, 32'h0000_0400);
      fetch_one(32'hAAAA_0003);
      consume(2'd2, 26'h0, 32'h1234_5677, 32'h0, 1'b0);
      chk("jr_target", imemAddr, 32'h1234_5674);

      // branches from pc=0x100
      fetch_one(32'hAAAA_0004);
      consume(2'd2, 26'h0, 32'h0000_0100, 32'h0, 1'b0);
      fetch_one(32'hAAAA_0005);
      consume(2'd3, 26'h0, 32'h0, 32'hFFFF_FFFE, 1'b1);
      chk("br_taken", imemAddr, 32'h0000_00FC);
      fetch_one(32'hAAAA_0006);
      consume(2'd2, 26'h0, 32'h0000_0100, 32'h0, 1'b0);
      fetch_one(32'hAAAA_0007);
      consume(2'd3, 26'h0, 32'h0, 32'hFFFF_FFFE, 1'b0);
      chk("br_not_taken", imemAddr, 32'h0000_0104);

      // ack delayed 3 cycles, then spurious ack in HOLD
      for (int c = 0; c < 3; c++) begin
         chk("wait_req",  {31'b0, imemReq}, 32'd1);
         chk("wait_addr", imemAddr, 32'h0000_0104);
         step();
      end
      chk("wait_req",  {31'b0, imemReq}, 32'd1);
      chk("wait_addr", imemAddr, 32'h0000_0104);
      fetch_one(32'hDEAD_BEEF);
      chk("late_instr", instr, 32'hDEAD_BEEF);
      chk("late_valid", {31'b0, instrValid}, 32'd1);
      imemAck = 1'b1; imemRData = 32'h1234_5678;
      step();
      imemAck = 1'b0;
      chk("spurious_instr", instr, 32'hDEAD_BEEF);

      // stall for 5 cycles
      r0 = m_ret;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("stall_instr",   instr, 32'hDEAD_BEEF);
         chk("stall_pc",      pc, 32'h0000_0104);
         chk("stall_retired", 32'(retired), 32'(r0));
         chk("stall_req",     {31'b0, imemReq}, 32'd0);
      end
      consume(2'd0, 26'h0, 32'h0, 32'h0, 1'b0);
      chk("unstall_retired", 32'(retired), 32'(IW'(r0 + 1'b1)));
      chk("unstall_addr", imemAddr, 32'h0000_0108);
      step();
      chk("unstall_once", 32'(retired), 32'(IW'(r0 + 1'b1)));

      // reset during a FETCH wait with coincident ack
      step();
      rstN = 1'b0; imemAck = 1'b1; imemRData = 32'h5555_AAAA;
      step();
      rstN = 1'b1; imemAck = 1'b0;
      chk("rstw_valid",   {31'b0, instrValid}, 32'd0);
      chk("rstw_req",     {31'b0, imemReq}, 32'd1);
      chk("rstw_addr",    imemAddr, 32'h0);
      chk("rstw_retired", 32'(retired), 32'd0);

      // reset overrides a consume in HOLD
      fetch_one(32'h0BAD_F00D);
      rstN = 1'b0; stall = 1'b0; pcSrcCtrl = 2'd2; jrTarget = 32'h0000_0500;
      step();
      rstN = 1'b1; stall = 1'b1; pcSrcCtrl = 2'd0;
      chk("rsth_addr",    imemAddr, 32'h0);
      chk("rsth_valid",   {31'b0, instrValid}, 32'd0);
      chk("rsth_retired", 32'(retired), 32'd0);

      // PC wrap at the top of the address space
      fetch_one(32'hCAFE_0001);
      consume(2'd2, 26'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
      chk("wrap_setup", imemAddr, 32'hFFFF_FFFC);
      fetch_one(32'hCAFE_0002);
      chk("wrap_pcplus4", pcPlus4, 32'h0);
      consume(2'd0, 26'h0, 32'h0, 32'h0, 1'b0);
      chk("wrap_addr", imemAddr, 32'h0);

      // drive the retired counter through its wrap
      for (int k = 0; k < 18; k++) begin
         fetch_one(32'h7000_0000 + 32'(k));
         consume(2'd0, 26'h0, 32'h0, 32'h0, 1'b0);
      end
      chk("retired_wrap", 32'(retired), 32'd4);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
